correlation_accumulator: RTL and testbench

CORRELATION_ACCUMULATOR -- requirements
Module: correlation_accumulator

---
 rtl/correlation_accumulator_if.sv | 35 +++
 rtl/correlation_accumulator.sv | 97 +++++++++
 tb/tb_correlation_accumulator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/correlation_accumulator_if.sv
// Line-in / window-sums-out handshake bundle for correlation_accumulator.
// The upstream stage and window consumer take the master side; the accumulator takes the slave side.
interface correlation_accumulator_if #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 8,
    parameter int NUM_TEMPLATES = 4,
    parameter int NUM_LINES     = 8
);
    localparam int PROD_W = 2 * PIXEL_SIZE;
    localparam int ACC_W  = PROD_W + $clog2(LINE_SIZE) + $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(NUM_LINES) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] I_square_in_line [LINE_SIZE];
    logic [PROD_W-1:0] I_in_line        [LINE_SIZE];
    logic [PROD_W-1:0] T_x_I_in_lines_transpose [NUM_TEMPLATES][LINE_SIZE];

    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum_I_square;
    logic [ACC_W-1:0]  sum_I;
    logic [ACC_W-1:0]  sum_T_x_I [NUM_TEMPLATES];
    logic [CNT_W-1:0]  line_cnt;

    modport master (
        output in_valid, I_square_in_line, I_in_line, T_x_I_in_lines_transpose, out_ready,
        input  in_ready, out_valid, sum_I_square, sum_I, sum_T_x_I, line_cnt
    );

    modport slave (
        input  in_valid, I_square_in_line, I_in_line, T_x_I_in_lines_transpose, out_ready,
        output in_ready, out_valid, sum_I_square, sum_I, sum_T_x_I, line_cnt
    );
endinterface

// File: rtl/correlation_accumulator.sv
// Accumulates NUM_LINES lines of I^2, I and per-template T*I sums into one window,
// then holds the window sums until the consumer takes them.
module correlation_accumulator #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 8,
    parameter int NUM_TEMPLATES = 4,
    parameter int NUM_LINES     = 8
) (
    input logic                       CLK,
    input logic                       RST,
    correlation_accumulator_if.slave  bus
);
    localparam int PROD_W = 2 * PIXEL_SIZE;
    localparam int ACC_W  = PROD_W + $clog2(LINE_SIZE) + $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(NUM_LINES) + 1;
    localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(NUM_LINES - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] line_cnt_q;
    logic [ACC_W-1:0] acc_sq;
    logic [ACC_W-1:0] acc_i;
    logic [ACC_W-1:0] acc_t [NUM_TEMPLATES];

    logic [ACC_W-1:0] line_sq;
    logic [ACC_W-1:0] line_i;
    logic [ACC_W-1:0] line_t [NUM_TEMPLATES];
    logic             accept;

    // NOTE: blocking assignments here chain the adds within one evaluation; the
    // defaults written first keep every path assigned, so no latch is inferred.
    always_comb begin
        line_sq = '0;
        line_i  = '0;
        for (int t = 0; t < NUM_TEMPLATES; t++) line_t[t] = '0;
        for (int p = 0; p < LINE_SIZE; p++) begin
            line_sq = line_sq + ACC_W'(bus.I_square_in_line[p]);
            line_i  = line_i  + ACC_W'(bus.I_in_line[p]);
            for (int t = 0; t < NUM_TEMPLATES; t++)
                line_t[t] = line_t[t] + ACC_W'(bus.T_x_I_in_lines_transpose[t][p]);
        end
    end

    assign accept = in_ready_q && bus.in_valid;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            line_cnt_q  <= '0;
            acc_sq      <= '0;
            acc_i       <= '0;
            for (int t = 0; t < NUM_TEMPLATES; t++) acc_t[t] <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc_sq     <= acc_sq + line_sq;
                        acc_i      <= acc_i + line_i;
                        for (int t = 0; t < NUM_TEMPLATES; t++) acc_t[t] <= acc_t[t] + line_t[t];
                        line_cnt_q <= line_cnt_q + CNT_W'(1);
                        if (line_cnt_q == LAST_LINE) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Window is consumed: clear so the next window starts from zero.
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        line_cnt_q  <= '0;
                        acc_sq      <= '0;
                        acc_i       <= '0;
                        for (int t = 0; t < NUM_TEMPLATES; t++) acc_t[t] <= '0;
                    end
                end
            endcase
        end
    end

    // The accumulators double as the outputs: partial sums in ACCUM, final sums in HOLD.
    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.line_cnt     = line_cnt_q;
    assign bus.sum_I_square = acc_sq;
    assign bus.sum_I        = acc_i;
    assign bus.sum_T_x_I    = acc_t;
endmodule

// File: tb/tb_correlation_accumulator.sv
// Bench for correlation_accumulator: a window-level model (queue of accepted line
// sums) checked every cycle, plus directed windows with hand-computed sums.
module tb_correlation_accumulator;
    localparam int P     = 8;
    localparam int L     = 8;
    localparam int NT    = 4;
    localparam int NL    = 8;
    localparam int ACC_W = 22;

    typedef struct packed {
        logic [31:0]          sq;
        logic [31:0]          i;
        logic [NT-1:0][31:0]  t;
    } line_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    line_t win [$];

    correlation_accumulator_if #(.PIXEL_SIZE(P), .LINE_SIZE(L), .NUM_TEMPLATES(NT), .NUM_LINES(NL)) bus ();

    correlation_accumulator #(.PIXEL_SIZE(P), .LINE_SIZE(L), .NUM_TEMPLATES(NT), .NUM_LINES(NL)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic line_t capture();
        line_t r;
        r = '0;
        for (int p = 0; p < L; p++) begin
            r.sq = r.sq + 32'(bus.I_square_in_line[p]);
            r.i  = r.i  + 32'(bus.I_in_line[p]);
            for (int t = 0; t < NT; t++) r.t[t] = r.t[t] + 32'(bus.T_x_I_in_lines_transpose[t][p]);
        end
        return r;
    endfunction

    // Window model: a window is full once NL lines are in; a full window waits for out_ready.
    always @(posedge clk) begin
        if (rst) win.delete();
        else if (win.size() == NL) begin
            if (bus.out_ready) win.delete();
        end else if (bus.in_valid) win.push_back(capture());
    end

    always @(negedge clk) begin
        logic [63:0] e_sq, e_i;
        logic [63:0] e_t [NT];
        e_sq = 0;
        e_i  = 0;
        for (int t = 0; t < NT; t++) e_t[t] = 0;
        foreach (win[k]) begin
            e_sq += 64'(win[k].sq);
            e_i  += 64'(win[k].i);
            for (int t = 0; t < NT; t++) e_t[t] += 64'(win[k].t[t]);
        end
        check("in_ready",     64'(bus.in_ready),  64'(win.size() < NL));
        check("out_valid",    64'(bus.out_valid), 64'(win.size() == NL));
        check("line_cnt",     64'(bus.line_cnt),  64'(win.size()));
        check("sum_I_square", 64'(bus.sum_I_square), e_sq);
        check("sum_I",        64'(bus.sum_I),        e_i);
        for (int t = 0; t < NT; t++)
            check($sformatf("sum_T_x_I[%0d]", t), 64'(bus.sum_T_x_I[t]), e_t[t]);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int p = 0; p < L; p++) begin
            bus.I_square_in_line[p] = v;
            bus.I_in_line[p]        = v;
            for (int t = 0; t < NT; t++) bus.T_x_I_in_lines_transpose[t][p] = v;
        end
    endtask

    task automatic set_random();
        for (int p = 0; p < L; p++) begin
            bus.I_square_in_line[p] = 16'($urandom);
            bus.I_in_line[p]        = 16'($urandom);
            for (int t = 0; t < NT; t++) bus.T_x_I_in_lines_transpose[t][p] = 16'($urandom);
        end
    endtask

    task automatic check_all_sums(input string tag, input logic [63:0] v);
        check({tag, " sum_I_square"}, 64'(bus.sum_I_square), v);
        check({tag, " sum_I"},        64'(bus.sum_I),        v);
        for (int t = 0; t < NT; t++)
            check($sformatf("%s sum_T_x_I[%0d]", tag, t), 64'(bus.sum_T_x_I[t]), v);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_all(16'h0);
        repeat (2) tick();
        check("reset in_ready",  64'(bus.in_ready),  64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset line_cnt",  64'(bus.line_cnt),  64'd0);
        check("reset sum_I",     64'(bus.sum_I),     64'd0);
        rst = 1'b0;

        // All-ones window: out_valid one cycle after the 8th acceptance.
        set_all(16'h1);
        bus.in_valid = 1'b1;
        repeat (7) tick();
        check("ones out_valid early", 64'(bus.out_valid), 64'd0);
        tick();
        check("ones out_valid", 64'(bus.out_valid), 64'd1);
        check_all_sums("ones", 64'd64);
        bus.in_valid = 1'b0;
        tick();
        check("ones in_ready after handshake", 64'(bus.in_ready), 64'd1);
        check("ones line_cnt cleared", 64'(bus.line_cnt), 64'd0);

        // Full-scale window must not wrap.
        set_all(16'hFFFF);
        bus.in_valid = 1'b1;
        repeat (8) tick();
        check("max out_valid", 64'(bus.out_valid), 64'd1);
        check_all_sums("max", 64'd4194240);
        bus.in_valid = 1'b0;
        tick();

        // Template j carries j+1, with random gaps between lines.
        set_all(16'h0);
        for (int t = 0; t < NT; t++)
            for (int p = 0; p < L; p++) bus.T_x_I_in_lines_transpose[t][p] = 16'(t + 1);
        for (int l = 0; l < NL; l++) begin
            bus.in_valid = 1'b1;
            tick();
            if (l < NL - 1) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
        end
        check("tmpl out_valid", 64'(bus.out_valid), 64'd1);
        check("tmpl sum_I",     64'(bus.sum_I),     64'd0);
        for (int t = 0; t < NT; t++)
            check($sformatf("tmpl sum_T_x_I[%0d]", t), 64'(bus.sum_T_x_I[t]), 64'(64 * (t + 1)));
        bus.in_valid = 1'b0;
        tick();

        // Back-pressure: out_ready low for 5 cycles with in_valid held high.
        bus.out_ready = 1'b0;
        set_all(16'h3);
        bus.in_valid = 1'b1;
        repeat (8) tick();
        set_all(16'h00FF);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("hold in_ready",  64'(bus.in_ready),  64'd0);
            check("hold out_valid", 64'(bus.out_valid), 64'd1);
            check("hold sum_I",     64'(bus.sum_I),     64'd192);
            check("hold line_cnt",  64'(bus.line_cnt),  64'(NL));
        end
        bus.out_ready = 1'b1;
        tick();
        check("post-hold line_cnt", 64'(bus.line_cnt), 64'd0);
        check("post-hold sum_I",    64'(bus.sum_I),    64'd0);
        bus.in_valid = 1'b0;
        tick();

        // Reset mid-window discards partial sums; first line after reset is taken.
        set_all(16'h5);
        bus.in_valid = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst line_cnt", 64'(bus.line_cnt), 64'd0);
        set_all(16'h2);
        repeat (8) tick();
        check("midrst out_valid", 64'(bus.out_valid), 64'd1);
        check("midrst sum_I",     64'(bus.sum_I),     64'd128);
        bus.in_valid = 1'b0;
        tick();

        // Back-to-back windows are independent.
        set_all(16'h7);
        bus.in_valid = 1'b1;
        repeat (8) tick();
        check("b2b first sum_I", 64'(bus.sum_I), 64'd448);
        set_all(16'h1);
        repeat (9) tick();
        check("b2b second out_valid", 64'(bus.out_valid), 64'd1);
        check("b2b second sum_I",     64'(bus.sum_I),     64'd64);

        // Random traffic, back-pressure and occasional resets.
        for (int c = 0; c < 800; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            set_random();
            tick();
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
